// File: rtl/valu_issue_ctrl.sv
// Purpose : issue/writeback controller for the vector ALU; decodes, checks RAW/WAW
//           hazards against a per-register pending scoreboard, drives valu, writes back.
// Latency : issue in cycle T -> wb_valid in cycle T+3; backpressure: in_ready drops while
//           a legal op names a pending register (illegal ops are always consumed).
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          instruction handshake from decode
//   in_funct7/in_funct3        operation / operand form (VV, VX, VI)
//   in_vd/in_vs1/in_vs2        destination and source register numbers
//   in_scalar/in_imm           VX scalar operand / VI immediate
//   vrf_raddr*/vrf_rdata*      combinational VRF read ports
//   alu_*                      valu inputs (NOP encoding when nothing issues)
//   alu_result/alu_valid       valu outputs; alu_valid is informational only
//   wb_valid/wb_vd/wb_data     registered VRF write port
//   err_illegal                one-cycle pulse after an illegal op was consumed
//   busy                       anything in flight or any register still pending
//   ops_retired                free-running writeback count
module valu_issue_ctrl #(
  parameter int VLEN      = 256,
  parameter int ELEM_SIZE = 32,
  parameter int NREGS     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // decode-side instruction handshake
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_funct7,
  input  logic [2:0]               in_funct3,
  input  logic [$clog2(NREGS)-1:0] in_vd,
  input  logic [$clog2(NREGS)-1:0] in_vs1,
  input  logic [$clog2(NREGS)-1:0] in_vs2,
  input  logic [ELEM_SIZE-1:0]     in_scalar,
  input  logic [ELEM_SIZE-1:0]     in_imm,
  // VRF read ports
  output logic [$clog2(NREGS)-1:0] vrf_raddr1,
  output logic [$clog2(NREGS)-1:0] vrf_raddr2,
  input  logic [VLEN-1:0]          vrf_rdata1,
  input  logic [VLEN-1:0]          vrf_rdata2,
  // valu interface
  output logic [VLEN-1:0]          alu_op1,
  output logic [VLEN-1:0]          alu_op2,
  output logic [ELEM_SIZE-1:0]     alu_imm,
  output logic                     alu_is_scalar,
  output logic [6:0]               alu_funct7,
  output logic [2:0]               alu_funct3,
  input  logic [VLEN-1:0]          alu_result,
  input  logic                     alu_valid,
  // VRF write port
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_vd,
  output logic [VLEN-1:0]          wb_data,
  // status
  output logic                     err_illegal,
  output logic                     busy,
  output logic [31:0]              ops_retired
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0000100;
  localparam logic [6:0] F7_MUL = 7'b1001011;
  localparam logic [6:0] F7_DIV = 7'b1001100;
  localparam logic [6:0] F7_NOP = 7'b1111111;

  localparam logic [2:0] F3_VV  = 3'b000;
  localparam logic [2:0] F3_VX  = 3'b100;
  localparam logic [2:0] F3_VI  = 3'b011;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [NREGS-1:0] pend_q,      pend_d;
  logic             s1_v_q,      s1_v_d;
  logic [AW-1:0]    s1_vd_q,     s1_vd_d;
  logic             s2_v_q,      s2_v_d;
  logic [AW-1:0]    s2_vd_q,     s2_vd_d;
  logic             wb_valid_q,  wb_valid_d;
  logic [AW-1:0]    wb_vd_q,     wb_vd_d;
  logic [VLEN-1:0]  wb_data_q,   wb_data_d;
  logic             err_q,       err_d;
  logic [31:0]      retired_q,   retired_d;

  // ------------------------------------------------------------------
  // Decode and hazard check
  // ------------------------------------------------------------------
  logic f7_ok;
  logic f3_ok;
  logic legal;
  logic is_vv;
  logic hazard;
  logic issue;
  logic take_illegal;

  always_comb begin
    f7_ok = (in_funct7 == F7_ADD) || (in_funct7 == F7_SUB) ||
            (in_funct7 == F7_MUL) || (in_funct7 == F7_DIV);
    f3_ok = (in_funct3 == F3_VV) || (in_funct3 == F3_VX) || (in_funct3 == F3_VI);
    legal = f7_ok && f3_ok;
    is_vv = (in_funct3 == F3_VV);
    // vs2 is only a real source in the VV form; vd pending covers WAW.
    hazard = pend_q[in_vs1] || (is_vv && pend_q[in_vs2]) || pend_q[in_vd];
  end

  // Illegal ops never wait: they touch neither the ALU nor the scoreboard.
  assign in_ready     = !legal || !hazard;
  // Gating with rst_n keeps the ALU at NOP while reset is held.
  assign issue        = rst_n && in_valid && legal && !hazard;
  assign take_illegal = in_valid && !legal;

  // ------------------------------------------------------------------
  // Operand steering to the valu
  // ------------------------------------------------------------------
  assign vrf_raddr1 = in_vs1;
  assign vrf_raddr2 = in_vs2;

  always_comb begin
    alu_op1       = '0;
    alu_op2       = '0;
    alu_imm       = '0;
    alu_is_scalar = 1'b0;
    alu_funct7    = F7_NOP;
    alu_funct3    = F3_VV;
    if (issue) begin
      alu_op1       = vrf_rdata1;
      alu_imm       = in_imm;
      alu_is_scalar = (in_funct3 == F3_VX);
      alu_funct7    = in_funct7;
      alu_funct3    = in_funct3;
      unique case (in_funct3)
        F3_VV:   alu_op2 = vrf_rdata2;
        F3_VX:   alu_op2 = VLEN'(in_scalar);
        default: alu_op2 = '0;   // VI: valu takes the immediate
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Tag pipeline, writeback capture, scoreboard
  // ------------------------------------------------------------------
  always_comb begin
    s1_v_d     = issue;
    s1_vd_d    = issue ? in_vd : s1_vd_q;
    s2_v_d     = s1_v_q;
    s2_vd_d    = s1_vd_q;
    wb_valid_d = s2_v_q;
    wb_vd_d    = wb_vd_q;
    wb_data_d  = wb_data_q;
    retired_d  = retired_q;
    err_d      = take_illegal;

    // s2 tracks the cycle in which valu presents its result.
    if (s2_v_q) begin
      wb_vd_d   = s2_vd_q;
      wb_data_d = alu_result;
      retired_d = retired_q + 32'd1;
    end

    // Clear when the VRF write happens; set is applied last so it wins.
    pend_d = pend_q;
    if (wb_valid_q) begin
      pend_d[wb_vd_q] = 1'b0;
    end
    if (issue) begin
      pend_d[in_vd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= '0;
      s1_v_q     <= 1'b0;
      s1_vd_q    <= '0;
      s2_v_q     <= 1'b0;
      s2_vd_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_vd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      retired_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      s1_v_q     <= s1_v_d;
      s1_vd_q    <= s1_vd_d;
      s2_v_q     <= s2_v_d;
      s2_vd_q    <= s2_vd_d;
      wb_valid_q <= wb_valid_d;
      wb_vd_q    <= wb_vd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      retired_q  <= retired_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign wb_valid    = wb_valid_q;
  assign wb_vd       = wb_vd_q;
  assign wb_data     = wb_data_q;
  assign err_illegal = err_q;
  assign ops_retired = retired_q;
  assign busy        = s1_v_q || s2_v_q || wb_valid_q || (|pend_q);

  // valu's valid is redundant with s2 by construction; kept only for observation.
  logic unused_alu_valid;
  assign unused_alu_valid = alu_valid;

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Bench for valu_issue_ctrl: models the 2-stage valu and the VRF, predicts each
// writeback at issue time into a queue and matches it against wb_* on arrival.
module tb_valu_issue_ctrl;

  localparam int VLEN      = 256;
  localparam int ELEM_SIZE = 32;
  localparam int NREGS     = 32;
  localparam int AW        = $clog2(NREGS);
  localparam int NE        = VLEN / ELEM_SIZE;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0000100;
  localparam logic [6:0] F7_MUL = 7'b1001011;
  localparam logic [6:0] F7_DIV = 7'b1001100;
  localparam logic [6:0] F7_NOP = 7'b1111111;
  localparam logic [2:0] F3_VV  = 3'b000;
  localparam logic [2:0] F3_VX  = 3'b100;
  localparam logic [2:0] F3_VI  = 3'b011;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           in_funct7;
  logic [2:0]           in_funct3;
  logic [AW-1:0]        in_vd, in_vs1, in_vs2;
  logic [ELEM_SIZE-1:0] in_scalar, in_imm;
  logic [AW-1:0]        vrf_raddr1, vrf_raddr2;
  logic [VLEN-1:0]      vrf_rdata1, vrf_rdata2;
  logic [VLEN-1:0]      alu_op1, alu_op2;
  logic [ELEM_SIZE-1:0] alu_imm;
  logic                 alu_is_scalar;
  logic [6:0]           alu_funct7;
  logic [2:0]           alu_funct3;
  logic [VLEN-1:0]      alu_result;
  logic                 alu_valid;
  logic                 wb_valid;
  logic [AW-1:0]        wb_vd;
  logic [VLEN-1:0]      wb_data;
  logic                 err_illegal;
  logic                 busy;
  logic [31:0]          ops_retired;

  valu_issue_ctrl #(.VLEN(VLEN), .ELEM_SIZE(ELEM_SIZE), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct7(in_funct7), .in_funct3(in_funct3),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_scalar(in_scalar), .in_imm(in_imm),
    .vrf_raddr1(vrf_raddr1), .vrf_raddr2(vrf_raddr2),
    .vrf_rdata1(vrf_rdata1), .vrf_rdata2(vrf_rdata2),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm),
    .alu_is_scalar(alu_is_scalar), .alu_funct7(alu_funct7), .alu_funct3(alu_funct3),
    .alu_result(alu_result), .alu_valid(alu_valid),
    .wb_valid(wb_valid), .wb_vd(wb_vd), .wb_data(wb_data),
    .err_illegal(err_illegal), .busy(busy), .ops_retired(ops_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- element arithmetic shared by valu model and predictor
  function automatic logic [ELEM_SIZE-1:0] elem_op(input logic [6:0] f7,
      input logic [ELEM_SIZE-1:0] x, input logic [ELEM_SIZE-1:0] y);
    case (f7)
      F7_ADD:  return x + y;
      F7_SUB:  return x - y;
      F7_MUL:  return x * y;
      F7_DIV:  return (y == '0) ? '1 : x / y;
      default: return '0;
    endcase
  endfunction

  // valu as seen from its pins: scalar in op2 low element, immediate on imm.
  function automatic logic [VLEN-1:0] valu_calc(input logic [6:0] f7, input logic [2:0] f3,
      input logic sc, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
      input logic [ELEM_SIZE-1:0] im);
    logic [VLEN-1:0] r;
    logic [ELEM_SIZE-1:0] y;
    r = '0;
    for (int e = 0; e < NE; e++) begin
      if (sc)               y = b[ELEM_SIZE-1:0];
      else if (f3 == F3_VI) y = im;
      else                  y = b[e*ELEM_SIZE +: ELEM_SIZE];
      r[e*ELEM_SIZE +: ELEM_SIZE] = elem_op(f7, a[e*ELEM_SIZE +: ELEM_SIZE], y);
    end
    return r;
  endfunction

  // Architectural result of an instruction from register contents.
  function automatic logic [VLEN-1:0] ref_calc(input logic [6:0] f7, input logic [2:0] f3,
      input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
      input logic [ELEM_SIZE-1:0] sc, input logic [ELEM_SIZE-1:0] im);
    logic [VLEN-1:0] r;
    logic [ELEM_SIZE-1:0] y;
    r = '0;
    for (int e = 0; e < NE; e++) begin
      case (f3)
        F3_VV:   y = b[e*ELEM_SIZE +: ELEM_SIZE];
        F3_VX:   y = sc;
        default: y = im;
      endcase
      r[e*ELEM_SIZE +: ELEM_SIZE] = elem_op(f7, a[e*ELEM_SIZE +: ELEM_SIZE], y);
    end
    return r;
  endfunction

  function automatic logic is_legal(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == F7_ADD || f7 == F7_SUB || f7 == F7_MUL || f7 == F7_DIV) &&
           (f3 == F3_VV || f3 == F3_VX || f3 == F3_VI);
  endfunction

  function automatic logic [VLEN-1:0] bcast(input logic [ELEM_SIZE-1:0] v);
    return {NE{v}};
  endfunction

  // ---------------- valu model: input register, then result register
  logic                 va_v, va_sc;
  logic [6:0]           va_f7;
  logic [2:0]           va_f3;
  logic [VLEN-1:0]      va_a, va_b;
  logic [ELEM_SIZE-1:0] va_im;
  logic                 vb_v;
  logic [VLEN-1:0]      vb_r;

  always @(posedge clk) begin
    if (!rst_n) begin
      va_v <= 1'b0; va_sc <= 1'b0; va_f7 <= F7_NOP; va_f3 <= '0;
      va_a <= '0; va_b <= '0; va_im <= '0; vb_v <= 1'b0; vb_r <= '0;
    end else begin
      va_v  <= is_legal(alu_funct7, alu_funct3);
      va_sc <= alu_is_scalar; va_f7 <= alu_funct7; va_f3 <= alu_funct3;
      va_a  <= alu_op1; va_b <= alu_op2; va_im <= alu_imm;
      vb_v  <= va_v;
      vb_r  <= va_v ? valu_calc(va_f7, va_f3, va_sc, va_a, va_b, va_im) : '0;
    end
  end
  assign alu_valid  = vb_v;
  assign alu_result = vb_r;

  // ---------------- VRF model
  logic [VLEN-1:0] vrf [NREGS] = '{default: '0};
  logic            pre_we;
  logic [AW-1:0]   pre_addr;
  logic [VLEN-1:0] pre_dat;

  always @(posedge clk) begin
    if (wb_valid) vrf[wb_vd] <= wb_data;
    if (pre_we)   vrf[pre_addr] <= pre_dat;
  end
  assign vrf_rdata1 = vrf[vrf_raddr1];
  assign vrf_rdata2 = vrf[vrf_raddr2];

  // ---------------- scoreboard
  typedef struct packed {
    logic [AW-1:0]   vd;
    logic [VLEN-1:0] data;
    logic [31:0]     due;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  exp_ret = 0;

  task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic monitor();
    sb_t  e;
    logic pav  = 1'b0;
    logic prst = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        exp_ret = 0;
      end else if (wb_valid) begin
        if (sbq.size() == 0) begin
          check("wb_unexpected", VLEN'(wb_valid), VLEN'(0));
        end else begin
          e = sbq.pop_front();
          exp_ret++;
          check("wb_vd", VLEN'(wb_vd), VLEN'(e.vd));
          check("wb_data", wb_data, e.data);
          check("wb_cycle", VLEN'(cyc), VLEN'(e.due));
        end
      end
      if (!in_valid || !rst_n) check("alu_nop", VLEN'(alu_funct7), VLEN'(F7_NOP));
      // valu valid in cycle c must be the tag that writes back in cycle c+1.
      if (prst) check("alu_valid_s2", VLEN'(wb_valid), VLEN'(pav));
      pav  = alu_valid;
      prst = rst_n;
    end
  endtask

  // ---------------- stimulus helpers (entered/left at #1 after a rising edge)
  task automatic load(input logic [AW-1:0] r, input logic [ELEM_SIZE-1:0] v);
    pre_we = 1'b1; pre_addr = r; pre_dat = bcast(v);
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic send(input logic [6:0] f7, input logic [2:0] f3,
      input logic [AW-1:0] vd, input logic [AW-1:0] vs1, input logic [AW-1:0] vs2,
      input logic [ELEM_SIZE-1:0] sc, input logic [ELEM_SIZE-1:0] im, output int waited);
    sb_t e;
    in_funct7 = f7; in_funct3 = f3; in_vd = vd; in_vs1 = vs1; in_vs2 = vs2;
    in_scalar = sc; in_imm = im; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("accept", VLEN'(in_ready), VLEN'(1));
    if (in_ready) begin
      if (is_legal(f7, f3)) begin
        check("issue_op1", alu_op1, vrf[vs1]);
        e.vd   = vd;
        e.data = ref_calc(f7, f3, vrf[vs1], vrf[vs2], sc, im);
        e.due  = cyc + 32'd3;
        sbq.push_back(e);
      end else begin
        check("illegal_nop", VLEN'(alu_funct7), VLEN'(F7_NOP));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || busy) && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("idle_busy", VLEN'(busy), VLEN'(0));
    check("idle_queue", VLEN'(sbq.size()), VLEN'(0));
    @(posedge clk); #1;
  endtask

  task automatic err_pulse(input string tag);
    @(negedge clk);
    check({tag, "_err_hi"}, VLEN'(err_illegal), VLEN'(1));
    @(negedge clk);
    check({tag, "_err_lo"}, VLEN'(err_illegal), VLEN'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int w, w2;
    rst_n = 1'b0; in_valid = 1'b0; in_funct7 = '0; in_funct3 = '0;
    in_vd = '0; in_vs1 = '0; in_vs2 = '0; in_scalar = '0; in_imm = '0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", VLEN'(wb_valid), VLEN'(0));
    check("rst_err", VLEN'(err_illegal), VLEN'(0));
    check("rst_busy", VLEN'(busy), VLEN'(0));
    check("rst_retired", VLEN'(ops_retired), VLEN'(0));
    check("rst_ready", VLEN'(in_ready), VLEN'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single VV ADD: 5 + 7
    load(1, 32'd5);
    load(2, 32'd7);
    send(F7_ADD, F3_VV, 5'd3, 5'd1, 5'd2, '0, '0, w);
    check("add_stall", VLEN'(w), VLEN'(0));
    wait_idle();
    check("add_v3", vrf[3], bcast(32'd12));
    check("add_retired", VLEN'(ops_retired), VLEN'(1));

    // VX SUB then VI MUL back-to-back
    load(1, 32'd10);
    send(F7_SUB, F3_VX, 5'd4, 5'd1, 5'd0, 32'd2, '0, w);
    send(F7_MUL, F3_VI, 5'd5, 5'd1, 5'd0, '0, 32'd3, w2);
    check("vx_stall", VLEN'(w), VLEN'(0));
    check("vi_stall", VLEN'(w2), VLEN'(0));
    wait_idle();
    check("vx_v4", vrf[4], bcast(32'd8));
    check("vi_v5", vrf[5], bcast(32'd30));

    // RAW stall: consumer of v6 waits three cycles
    send(F7_ADD, F3_VV, 5'd6, 5'd1, 5'd2, '0, '0, w);
    send(F7_SUB, F3_VV, 5'd7, 5'd6, 5'd1, '0, '0, w2);
    check("raw_stall", VLEN'(w2), VLEN'(3));
    wait_idle();
    check("raw_v7", vrf[7], bcast(32'd7));

    // WAW stall on v8
    send(F7_ADD, F3_VV, 5'd8, 5'd1, 5'd2, '0, '0, w);
    send(F7_SUB, F3_VX, 5'd8, 5'd2, 5'd0, 32'd1, '0, w2);
    check("waw_stall", VLEN'(w2), VLEN'(3));
    wait_idle();
    check("waw_v8", vrf[8], bcast(32'd6));

    // illegal ops: consumed at once even when naming pending registers
    send(F7_ADD, F3_VV, 5'd10, 5'd1, 5'd2, '0, '0, w);
    send(7'b0000001, F3_VV, 5'd10, 5'd10, 5'd10, '0, '0, w2);
    check("ill7_stall", VLEN'(w2), VLEN'(0));
    err_pulse("ill7");
    send(F7_ADD, 3'b010, 5'd11, 5'd1, 5'd2, '0, '0, w2);
    check("ill3_stall", VLEN'(w2), VLEN'(0));
    err_pulse("ill3");
    send(F7_ADD, F3_VV, 5'd17, 5'd11, 5'd1, '0, '0, w2);
    check("ill_no_pend", VLEN'(w2), VLEN'(0));
    wait_idle();

    // DIV by zero, then a regular divide
    load(1, 32'd100);
    load(2, 32'd0);
    send(F7_DIV, F3_VV, 5'd12, 5'd1, 5'd2, '0, '0, w);
    wait_idle();
    check("div0_v12", vrf[12], bcast(32'hFFFF_FFFF));
    load(2, 32'd7);
    send(F7_DIV, F3_VV, 5'd13, 5'd1, 5'd2, '0, '0, w);
    wait_idle();
    check("div_v13", vrf[13], bcast(32'd14));

    // reset with two ops in flight and a legal op offered during reset
    send(F7_ADD, F3_VV, 5'd14, 5'd1, 5'd2, '0, '0, w);
    send(F7_SUB, F3_VV, 5'd15, 5'd1, 5'd2, '0, '0, w);
    rst_n = 1'b0;
    in_funct7 = F7_ADD; in_funct3 = F3_VV; in_vd = 5'd16; in_vs1 = 5'd1; in_vs2 = 5'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", VLEN'(busy), VLEN'(0));
    check("mid_rst_retired", VLEN'(ops_retired), VLEN'(0));
    repeat (6) @(negedge clk);
    check("mid_rst_quiet", VLEN'(busy), VLEN'(0));
    @(posedge clk); #1;
    send(F7_ADD, F3_VV, 5'd14, 5'd14, 5'd14, '0, '0, w);
    check("mid_rst_ready", VLEN'(w), VLEN'(0));
    wait_idle();
    check("final_retired", VLEN'(ops_retired), VLEN'(exp_ret));
    check("final_retired_1", VLEN'(ops_retired), VLEN'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
